// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair.
// One iteration per cycle; a start/busy/done handshake lets the core stall on busy.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*WIDTH-1:0]     acc_q, acc_nxt;
  logic [WIDTH-1:0]       opnd_q;
  logic                   is_div_q, neg_q, neg_r_q, done_q;
  logic [WIDTH-1:0]       hi_q, lo_q;

  logic                   accept, mt_write, last_iter, finish;
  logic                   signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         mul_sum, div_diff;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       quot, rem, res_hi, res_lo;

  assign accept    = (state_q == StIdle) && start_i && !flush_i && !op_i[2];
  assign mt_write  = (state_q == StIdle) && start_i && !flush_i && (op_i[2:1] == 2'b10);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign finish    = (state_q == StCalc) && last_iter && !flush_i;

  assign signed_op = !op_i[0];
  assign a_neg     = signed_op && a_i[WIDTH-1];
  assign b_neg     = signed_op && b_i[WIDTH-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (!is_div_q) begin
      acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_nxt = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quot = acc_nxt[WIDTH-1:0];
    rem  = acc_nxt[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      res_lo = neg_q ? -quot : quot;
      res_hi = neg_r_q ? -rem : rem;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: if (flush_i || last_iter) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q == StCalc);
    done_o = done_q;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= finish;
      if (accept) begin
        cnt_q    <= '0;
        is_div_q <= op_i[1];
        neg_r_q  <= a_neg;
        if (op_i[1]) begin
          acc_q  <= {{WIDTH{1'b0}}, a_mag};
          opnd_q <= b_mag;
          // Divide by zero keeps the all-ones quotient unsigned.
          neg_q  <= (a_neg ^ b_neg) && (b_i != '0);
        end else begin
          acc_q  <= {{WIDTH{1'b0}}, b_mag};
          opnd_q <= a_mag;
          neg_q  <= a_neg ^ b_neg;
        end
      end else if (state_q == StCalc) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_nxt;
      end
      if (finish) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (mt_write) begin
        if (op_i[0]) lo_q <= a_i;
        else         hi_q <= a_i;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: expected {HI,LO} queued at issue,
// popped and compared by a monitor whenever done_o is seen.
module tb_mips_muldiv_unit;

  localparam int unsigned W = 32;
  localparam logic [2:0] OpMult = 3'b000, OpMultu = 3'b001, OpDiv = 3'b010,
                         OpDivu = 3'b011, OpMthi = 3'b100, OpMtlo = 3'b101;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [2:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         flush_i = 1'b0;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [2*W-1:0] sb[$];

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi_o, lo_o);
      end else begin
        check("result_hilo", {hi_o, lo_o}, sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int busy_cnt;
    #2;
    check("reset_hilo", {hi_o, lo_o}, '0);
    check("reset_busy_done", {62'd0, busy_o, done_o}, '0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // MULTU max*max with busy-length measurement.
    sb.push_back(64'hFFFFFFFE_00000001);
    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_o) break;
      busy_cnt++;
    end
    check("multu_busy_cycles", 64'(busy_cnt), 64'd32);
    check("multu_done_after_busy", {63'd0, done_o}, 64'd1);

    // Back-to-back signed ops, second accepted in the done cycle.
    sb.push_back(64'hFFFFFFFF_FFFFFFEB);
    issue(OpMult, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult");
    sb.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    check("b2b_busy_no_gap", {63'd0, busy_o}, 64'd1);
    wait_done("div");

    // Divide boundaries.
    sb.push_back({32'h0000_0007, 32'hFFFF_FFFF});
    issue(OpDivu, 32'd7, 32'd0);
    wait_done("divu_zero");
    sb.push_back({32'h0000_0000, 32'h8000_0000});
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf");
    @(negedge clk);

    // MTHI/MTLO take effect at the accepting edge without busy.
    issue(OpMthi, 32'h1234, 32'd0);
    check("mthi_hi", 64'(hi_o), 64'h1234);
    check("mthi_busy", {63'd0, busy_o}, 64'd0);
    issue(OpMtlo, 32'h5678, 32'd0);
    check("mtlo_lo", 64'(lo_o), 64'h5678);

    // Flush in CALC cycle 10; a start during CALC must be ignored.
    issue(OpMultu, 32'd5, 32'd6);
    repeat (4) @(posedge clk);
    #1;
    issue(OpMthi, 32'hDEAD, 32'd0);
    repeat (4) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("flush_busy_low", {63'd0, busy_o}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hilo_kept", {hi_o, lo_o}, {32'h1234, 32'h5678});

    // Asynchronous reset mid-DIVU.
    issue(OpDivu, 32'd100, 32'd7);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hilo", {hi_o, lo_o}, '0);
    check("async_rst_busy_done", {62'd0, busy_o, done_o}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back(64'd12);
    issue(OpMultu, 32'd3, 32'd4);
    wait_done("multu_after_rst");
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
